speed_ctrl_fsm: RTL and testbench

//   Control FSM that sequences the speed-measurement datapath and its barrier.

---
 rtl/speed_ctrl_pkg.sv | 20 ++
 rtl/edge_sync.sv | 28 ++
 rtl/speed_ctrl_fsm.sv | 167 ++++++++++++++++
 tb/tb_speed_ctrl_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/speed_ctrl_pkg.sv
// Shared constants for the speed-measurement controller: state codes,
// ms counter width and the clock-to-millisecond prescale helper.
package speed_ctrl_pkg;

  localparam int MS_CNT_W = 16;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] COUNT  = 3'd2;
  localparam logic [2:0] CALC   = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DECIDE = 3'd5;
  localparam logic [2:0] OPEN   = 3'd6;

  // Clocks per millisecond: MS_PRESCALE = SYS_FREQ/1000.
  function automatic int ms_prescale(input int sys_freq);
    return sys_freq / 1000;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// The rise pulse appears three clocks after the raw input goes high.
module edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      rise  <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/speed_ctrl_fsm.sv
// Sequencing FSM for the speed datapath and barrier; all outputs registered.
// Optional saturating violation counter is built when VIOLATION_CNT_EN is defined.
module speed_ctrl_fsm
  import speed_ctrl_pkg::*;
#(
  parameter int WIDTH_SPEED = 14,
  parameter int SYS_FREQ    = 50000000,
  parameter int SPEED_LIMIT = 60,
  parameter int TIMEOUT_MS  = 5000,
  parameter int HOLD_MS     = 3000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sensor1,
  input  logic                   sensor2,
  input  logic [WIDTH_SPEED-1:0] speed,
  input  logic                   done,
  output logic                   init,
  output logic                   count,
  output logic                   cal,
  output logic                   up,
  output logic                   down,
  output logic                   en,
  output logic                   dis,
  output logic                   overspeed,
  output logic                   timeout,
  output logic                   busy,
  output logic [7:0]             violation_cnt
);

  localparam int MS_PRESCALE = ms_prescale(SYS_FREQ);
  localparam int PRE_W = (MS_PRESCALE > 1) ? $clog2(MS_PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MS_PRESCALE - 1);

  logic                   s1_rise;
  logic                   s2_rise;
  logic [2:0]             state_reg;
  logic [2:0]             state_next;
  logic [PRE_W-1:0]       pre_reg;
  logic [MS_CNT_W-1:0]    ms_reg;
  logic [WIDTH_SPEED-1:0] speed_reg;
  logic init_next, count_next, cal_next, up_next, down_next;
  logic en_next, dis_next, overspeed_next, timeout_next, busy_next;

  edge_sync u_sync_s1 (.clk(clk), .reset_n(reset_n), .din(sensor1), .rise(s1_rise));
  edge_sync u_sync_s2 (.clk(clk), .reset_n(reset_n), .din(sensor2), .rise(s2_rise));

  // Outputs are decoded from the transition and registered alongside the state.
  always_comb begin
    state_next     = state_reg;
    init_next      = 1'b0;
    cal_next       = 1'b0;
    up_next        = 1'b0;
    down_next      = 1'b0;
    en_next        = 1'b0;
    dis_next       = 1'b0;
    overspeed_next = 1'b0;
    timeout_next   = 1'b0;
    case (state_reg)
      IDLE: if (s1_rise) begin
        state_next = ARM;
        init_next  = 1'b1;
      end
      ARM: state_next = COUNT;
      COUNT: begin
        if (s2_rise) begin
          state_next = CALC;
          cal_next   = 1'b1;
        end else if (ms_reg == MS_CNT_W'(TIMEOUT_MS)) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
          init_next    = 1'b1;
        end
      end
      CALC: state_next = WAIT;
      WAIT: if (done) state_next = DECIDE;
      DECIDE: begin
        if (speed_reg > WIDTH_SPEED'(SPEED_LIMIT)) begin
          state_next     = IDLE;
          overspeed_next = 1'b1;
          dis_next       = 1'b1;
        end else begin
          state_next = OPEN;
          en_next    = 1'b1;
          up_next    = 1'b1;
        end
      end
      OPEN: if (ms_reg == MS_CNT_W'(HOLD_MS)) begin
        state_next = IDLE;
        dis_next   = 1'b1;
        down_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
    count_next = (state_next == COUNT);
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      init      <= 1'b0;
      count     <= 1'b0;
      cal       <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      en        <= 1'b0;
      dis       <= 1'b0;
      overspeed <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      init      <= init_next;
      count     <= count_next;
      cal       <= cal_next;
      up        <= up_next;
      down      <= down_next;
      en        <= en_next;
      dis       <= dis_next;
      overspeed <= overspeed_next;
      timeout   <= timeout_next;
      busy      <= busy_next;
    end
  end

  // Millisecond timebase restarts from zero on every state entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_reg <= '0;
      ms_reg  <= '0;
    end else if (state_next != state_reg) begin
      pre_reg <= '0;
      ms_reg  <= '0;
    end else if (pre_reg == PRE_LAST) begin
      pre_reg <= '0;
      ms_reg  <= ms_reg + 1'b1;
    end else begin
      pre_reg <= pre_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      speed_reg <= '0;
    end else if (state_reg == WAIT && done) begin
      speed_reg <= speed;
    end
  end

`ifdef VIOLATION_CNT_EN
  logic [7:0] viol_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_reg <= 8'd0;
    end else if (overspeed_next && viol_reg != 8'hFF) begin
      viol_reg <= viol_reg + 8'd1;
    end
  end

  assign violation_cnt = viol_reg;
`else
  assign violation_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_speed_ctrl_fsm.sv
// Directed scoreboard bench for speed_ctrl_fsm (1 ms = 10 clk, shortened timeouts).
// Strobe events are predicted with their cycle and matched by a monitor.
module tb_speed_ctrl_fsm;

  localparam int P     = 10;
  localparam int T_MS  = 50;
  localparam int H_MS  = 30;
  localparam int LIMIT = 60;

  localparam logic [7:0] EV_INIT = 8'h80;
  localparam logic [7:0] EV_CAL  = 8'h40;
  localparam logic [7:0] EV_EN   = 8'h20;
  localparam logic [7:0] EV_DIS  = 8'h10;
  localparam logic [7:0] EV_UP   = 8'h08;
  localparam logic [7:0] EV_DOWN = 8'h04;
  localparam logic [7:0] EV_OVR  = 8'h02;
  localparam logic [7:0] EV_TMO  = 8'h01;

  typedef struct {
    int         cyc;
    logic [7:0] ev;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sensor1, sensor2, done;
  logic [13:0] speed;
  logic        init, count, cal, up, down, en, dis, overspeed, timeout, busy;
  logic [7:0]  violation_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t got;
  logic [7:0] ev;
  int   e;
  int   c;

  speed_ctrl_fsm #(
    .WIDTH_SPEED(14), .SYS_FREQ(10000), .SPEED_LIMIT(LIMIT),
    .TIMEOUT_MS(T_MS), .HOLD_MS(H_MS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sensor1(sensor1), .sensor2(sensor2),
    .speed(speed), .done(done), .init(init), .count(count), .cal(cal),
    .up(up), .down(down), .en(en), .dis(dis), .overspeed(overspeed),
    .timeout(timeout), .busy(busy), .violation_cnt(violation_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic push(input int at, input logic [7:0] v);
    exp_q.push_back('{cyc: at, ev: v});
  endtask

  // One vehicle pass: s1, s2 after s2_ms, done 14 clk after cal with speed spd.
  task automatic run_vehicle(input logic [13:0] spd, input int s2_ms, input bit both,
                             output int e_out);
    int c0, d;
    c0 = cyc;
    sensor1 = 1'b1;
    sensor2 = both;
    push(c0 + 4, EV_INIT);
    tick(3);
    sensor1 = 1'b0;
    sensor2 = 1'b0;
    check("count_idle", count, 0);
    tick(3);
    check("count_level", count, 1);
    check("busy_count", busy, 1);
    if (both) begin
      sensor1 = 1'b1;
      tick(3);
      sensor1 = 1'b0;
      tick(s2_ms * P - 9);
    end else begin
      tick(s2_ms * P - 6);
    end
    d = cyc;
    sensor2 = 1'b1;
    push(d + 4, EV_CAL);
    tick(3);
    sensor2 = 1'b0;
    check("count_s2", count, 1);
    tick(1);
    check("count_calc", count, 0);
    tick(14);
    e_out = cyc;
    speed = spd;
    done  = 1'b1;
    if (spd > LIMIT) begin
      push(e_out + 2, EV_OVR | EV_DIS);
    end else begin
      push(e_out + 2, EV_EN | EV_UP);
      push(e_out + 3 + H_MS * P, EV_DIS | EV_DOWN);
    end
    tick(1);
    done  = 1'b0;
    speed = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      ev = {init, cal, en, dis, up, down, overspeed, timeout};
      if (ev != 8'h00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {24'd0, ev}, 32'd0);
        end else begin
          got = exp_q.pop_front();
          $display("event cycle %0d strobes %02h (expected %02h at %0d)", cyc, ev, got.ev, got.cyc);
          check("event_strobes", {24'd0, ev}, {24'd0, got.ev});
          check("event_cycle", cyc, got.cyc);
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    sensor1 = 1'b0;
    sensor2 = 1'b0;
    done    = 1'b0;
    speed   = '0;
    tick(3);
    check("rst_outs", {init, count, cal, up, down, en, dis, overspeed, timeout, busy}, 0);
    check("rst_viol", violation_cnt, 0);
    reset_n = 1'b1;
    tick(2);

    sensor2 = 1'b1;
    tick(3);
    sensor2 = 1'b0;
    tick(6);
    check("s2_alone_busy", busy, 0);

    run_vehicle(14'd40, 20, 1'b0, e);
    tick(H_MS * P + 3);
    check("busy_after_hold", busy, 0);

    run_vehicle(14'd60, 20, 1'b0, e);
    tick(H_MS * P + 3);
    check("busy_limit_equal", busy, 0);

    run_vehicle(14'd61, 20, 1'b0, e);
    tick(3);
    check("busy_after_viol", busy, 0);
`ifdef VIOLATION_CNT_EN
    check("viol_cnt_1", violation_cnt, 1);
`else
    check("viol_cnt_off", violation_cnt, 0);
`endif

    run_vehicle(14'h2000, 20, 1'b0, e);
    tick(3);
`ifdef VIOLATION_CNT_EN
    check("viol_cnt_2", violation_cnt, 2);
`else
    check("viol_cnt_off2", violation_cnt, 0);
`endif

    run_vehicle(14'd40, 20, 1'b1, e);
    tick(50);
    check("busy_open", busy, 1);
    check("pending_before_rst", exp_q.size(), 1);
    reset_n = 1'b0;
    #1;
    check("rst_async_outs", {init, count, cal, up, down, en, dis, overspeed, timeout, busy}, 0);
    check("rst_async_viol", violation_cnt, 0);
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(2);

    c = cyc;
    sensor1 = 1'b1;
    push(c + 4, EV_INIT);
    push(c + 6 + T_MS * P, EV_INIT | EV_TMO);
    tick(3);
    sensor1 = 1'b0;
    tick(T_MS * P + 6);
    check("busy_after_timeout", busy, 0);
    check("count_after_timeout", count, 0);

`ifdef VIOLATION_CNT_EN
    for (int i = 0; i < 255; i++) begin
      run_vehicle(14'd100, 1, 1'b0, e);
      tick(3);
    end
    check("viol_cnt_255", violation_cnt, 255);
    run_vehicle(14'd100, 1, 1'b0, e);
    tick(3);
    check("viol_cnt_sat", violation_cnt, 255);
`endif

    tick(5);
    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
